// File: rtl/fifo_read_adapter_pkg.sv
// Shared types and constants for the FIFO read adapter and its skid buffer.
package fifo_read_adapter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int SKID_DEPTH = 3;
  localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  // Circular-buffer pointer advance; depth is not a power of two.
  function automatic logic [SKID_PTR_W-1:0] ptr_inc(input logic [SKID_PTR_W-1:0] p);
    return (p == SKID_PTR_W'(SKID_DEPTH - 1)) ? '0 : p + SKID_PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_read_adapter_skid.sv
// 3-entry circular buffer of {tag, data} that absorbs the FIFO's one-cycle read latency.
module read_skid_buffer
  import fifo_read_adapter_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_wr,
  input  logic [BIT_WIDTH-1:0]  i_wr_data,
  input  logic                  i_wr_tag,
  input  logic                  i_pop,
  output logic [SKID_CNT_W-1:0] o_count,
  output logic [BIT_WIDTH-1:0]  o_head_data,
  output logic                  o_head_tag
);

  logic [BIT_WIDTH:0]    r_mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] r_wr_ptr;
  logic [SKID_PTR_W-1:0] r_rd_ptr;
  logic [SKID_CNT_W-1:0] r_count;
  logic                  w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wr_ptr] <= {i_wr_tag, i_wr_data};
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_wr, w_pop})
        2'b10:   r_count <= r_count + SKID_CNT_W'(1);
        2'b01:   r_count <= r_count - SKID_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The dequeue gate keeps count + inflight below depth, so a write into a full buffer is a bug.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(i_wr && !w_pop && !i_clear && r_count == SKID_CNT_W'(SKID_DEPTH)));

  assign o_count                   = r_count;
  assign {o_head_tag, o_head_data} = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_read_adapter.sv
// Drains mixed_clock_fifo in BURST_LEN bursts onto a valid/ready stream with a last marker.
// Optional burst counter output enabled by FIFO_READ_ADAPTER_STATS_EN.
module fifo_read_adapter
  import fifo_read_adapter_pkg::*;
#(
  parameter int  CAPACITY  = 3,
  parameter int  BIT_WIDTH = 8,
  parameter int  BURST_LEN = 2,
  localparam int PW        = $clog2(CAPACITY + 1)
) (
  input  logic                 read_clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [BIT_WIDTH-1:0] fifo_data_out,
  input  logic [PW-1:0]        fifo_population,
  input  logic                 fifo_empty,
  output logic                 fifo_dequeue,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output state_t               o_dbg_state
`ifdef FIFO_READ_ADAPTER_STATS_EN
  ,
  output logic [15:0]          burst_count
`endif
);

  localparam int IW = $clog2(BURST_LEN + 1);

  if (BURST_LEN < 1 || BURST_LEN > CAPACITY) begin : g_bad_burst_len
    $fatal(1, "fifo_read_adapter: BURST_LEN must be within 1..CAPACITY");
  end

  // Stream handshake: a word transfers on a clock edge where out_valid && out_ready;
  // once out_valid is high, out_data/out_last hold until that transfer.
  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_issued;
  logic                  r_inflight;
  logic                  r_inflight_tag;
  logic [SKID_CNT_W-1:0] w_count;
  logic [BIT_WIDTH-1:0]  w_head_data;
  logic                  w_head_tag;
  logic                  w_valid;
  logic                  w_xfer;
  logic                  w_last_xfer;
  logic                  w_deq;

  assign w_valid     = (w_count != '0);
  assign w_xfer      = w_valid && out_ready;
  assign w_last_xfer = w_xfer && w_head_tag;

  always_comb begin
    w_state_nxt = r_state;
    w_deq       = 1'b0;
    case (r_state)
      IDLE:    if (fifo_population >= PW'(BURST_LEN)) w_state_nxt = BURST;
      BURST:   if (w_last_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
    // Never depends on out_ready: buffer room is counted including the word in flight.
    if (r_state == BURST && r_issued < IW'(BURST_LEN) && !fifo_empty &&
        ((SKID_CNT_W + 1)'(w_count) + (SKID_CNT_W + 1)'(r_inflight)) < (SKID_CNT_W + 1)'(SKID_DEPTH))
      w_deq = 1'b1;
  end

  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_issued       <= '0;
      r_inflight     <= 1'b0;
      r_inflight_tag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_issued       <= '0;
        r_inflight     <= 1'b0;
        r_inflight_tag <= 1'b0;
      end else begin
        if (r_state == IDLE) r_issued <= '0;
        else if (w_deq)      r_issued <= r_issued + IW'(1);
        r_inflight     <= w_deq;
        r_inflight_tag <= w_deq && (r_issued == IW'(BURST_LEN - 1));
      end
    end
  end

  read_skid_buffer #(.BIT_WIDTH(BIT_WIDTH)) u_skid (
    .clk         (read_clock),
    .rst_n       (reset_n),
    .i_clear     (flush),
    .i_wr        (r_inflight),
    .i_wr_data   (fifo_data_out),
    .i_wr_tag    (r_inflight_tag),
    .i_pop       (w_xfer),
    .o_count     (w_count),
    .o_head_data (w_head_data),
    .o_head_tag  (w_head_tag)
  );

  assign fifo_dequeue = w_deq;
  assign out_valid    = w_valid;
  assign out_data     = w_valid ? w_head_data : '0;
  assign out_last     = w_valid && w_head_tag;
  assign o_dbg_state  = r_state;

`ifdef FIFO_READ_ADAPTER_STATS_EN
  logic [15:0] r_burst_count;

  // Only reset clears the counter; flush leaves it alone.
  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n)         r_burst_count <= '0;
    else if (w_last_xfer) r_burst_count <= r_burst_count + 16'd1;
  end

  assign burst_count = r_burst_count;
`endif

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Bench for fifo_read_adapter: instance A (BURST_LEN 2) and B (BURST_LEN 3), each fed by a FIFO model.
module tb_fifo_read_adapter;
  import fifo_read_adapter_pkg::*;

  localparam int W  = 8;
  localparam int PW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, out_ready;
  logic [W-1:0]  a_fdata, b_fdata, a_data, b_data;
  logic [PW-1:0] a_popn, b_popn;
  logic          a_empty, b_empty, a_deq, b_deq, a_valid, b_valid, a_last, b_last;
  state_t        a_state, b_state;
`ifdef FIFO_READ_ADAPTER_STATS_EN
  logic [15:0]   a_bcount, b_bcount;
`endif

  logic [W-1:0] a_fq[$], b_fq[$];
  logic [W:0]   exp_a_q[$], exp_b_q[$], got_a_q[$], got_b_q[$];
  int           got_a_cyc[$], got_b_cyc[$];
  int           cycle = 0, a_deq_cnt = 0, b_deq_cnt = 0;
  int           n_tests = 0, n_fail = 0;

  fifo_read_adapter #(.CAPACITY(3), .BIT_WIDTH(W), .BURST_LEN(2)) u_dut_a (
    .read_clock(clk), .reset_n(rst_n), .flush(flush), .fifo_data_out(a_fdata),
    .fifo_population(a_popn), .fifo_empty(a_empty), .fifo_dequeue(a_deq),
    .out_data(a_data), .out_valid(a_valid), .out_last(a_last), .out_ready(out_ready),
    .o_dbg_state(a_state)
`ifdef FIFO_READ_ADAPTER_STATS_EN
    , .burst_count(a_bcount)
`endif
  );

  fifo_read_adapter #(.CAPACITY(3), .BIT_WIDTH(W), .BURST_LEN(3)) u_dut_b (
    .read_clock(clk), .reset_n(rst_n), .flush(flush), .fifo_data_out(b_fdata),
    .fifo_population(b_popn), .fifo_empty(b_empty), .fifo_dequeue(b_deq),
    .out_data(b_data), .out_valid(b_valid), .out_last(b_last), .out_ready(out_ready),
    .o_dbg_state(b_state)
`ifdef FIFO_READ_ADAPTER_STATS_EN
    , .burst_count(b_bcount)
`endif
  );

  task automatic sync_fifo();
    a_popn  = PW'(a_fq.size());
    a_empty = (a_fq.size() == 0);
    b_popn  = PW'(b_fq.size());
    b_empty = (b_fq.size() == 0);
  endtask

  task automatic push_a(input logic [W-1:0] v);
    a_fq.push_back(v);
    sync_fifo();
  endtask

  task automatic push_b(input logic [W-1:0] v);
    b_fq.push_back(v);
    sync_fifo();
  endtask

  // One clock: record pre-edge transfers/dequeues, then advance the FIFO models after the edge.
  task automatic step();
    logic a_d, b_d;
    a_d = a_deq;
    b_d = b_deq;
    if (a_valid && out_ready) begin
      got_a_q.push_back({a_last, a_data});
      got_a_cyc.push_back(cycle + 1);
    end
    if (b_valid && out_ready) begin
      got_b_q.push_back({b_last, b_data});
      got_b_cyc.push_back(cycle + 1);
    end
    if (a_d) a_deq_cnt++;
    if (b_d) b_deq_cnt++;
    @(posedge clk);
    #1;
    cycle++;
    if (flush || !rst_n) begin
      a_fq.delete();
      b_fq.delete();
    end else begin
      if (a_d && a_fq.size() > 0) a_fdata = a_fq.pop_front();
      if (b_d && b_fq.size() > 0) b_fdata = b_fq.pop_front();
    end
    sync_fifo();
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; a_fdata = '0; b_fdata = '0;
    sync_fifo();
    step(); step();
    n_tests++;
    if ({a_valid, a_last, a_deq, a_data} !== '0) begin
      n_fail++; $display("FAIL reset_a_outputs: got v%0b l%0b d%0b data %0d, expected all 0", a_valid, a_last, a_deq, a_data);
    end
    n_tests++;
    if ({b_valid, b_last, b_deq, b_data} !== '0) begin
      n_fail++; $display("FAIL reset_b_outputs: got v%0b l%0b d%0b data %0d, expected all 0", b_valid, b_last, b_deq, b_data);
    end
    n_tests++;
    if (a_state !== IDLE || b_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d/%0d expected IDLE", a_state, b_state);
    end
`ifdef FIFO_READ_ADAPTER_STATS_EN
    n_tests++;
    if (a_bcount !== 16'd0) begin
      n_fail++; $display("FAIL reset_burst_count: got %0d expected 0", a_bcount);
    end
`endif
    rst_n = 1'b1;
    repeat (20) step();
    n_tests++;
    if (a_deq_cnt + b_deq_cnt != 0) begin
      n_fail++; $display("FAIL reset_no_dequeue: got %0d dequeues expected 0", a_deq_cnt + b_deq_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    int k;
    out_ready = 1'b0;
    push_a(8'd7); push_a(8'd8); push_a(8'd9);
    k = 0;
    while (!a_valid && k < 30) begin step(); k++; end
    n_tests++;
    if (!a_valid) begin n_fail++; $display("FAIL midreset_wait: out_valid never rose, expected within 30 cycles"); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (a_valid !== 1'b0 || a_deq !== 1'b0 || a_state !== IDLE) begin
      n_fail++; $display("FAIL midreset_async: got v%0b d%0b st%0d expected 0 0 IDLE", a_valid, a_deq, a_state);
    end
    step();
    rst_n = 1'b1;
    do_flush();
    out_ready = 1'b1;
    repeat (3) step();
    n_tests++;
    if (got_a_q.size() != 0 || a_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_lost: got %0d words valid %0b expected 0 words valid 0", got_a_q.size(), a_valid);
    end
    got_a_q.delete(); got_a_cyc.delete();
  endtask

  task automatic test_single_burst();
    int base, d0, k, c;
    int cyc[2];
    logic [W:0] e, g;
    out_ready = 1'b1;
    push_a(8'd100); push_a(8'd255); push_a(8'd120);
    exp_a_q.push_back({1'b0, 8'd100});
    exp_a_q.push_back({1'b1, 8'd255});
    base = cycle; d0 = a_deq_cnt;
    k = 0;
    while (got_a_q.size() < 2 && k < 30) begin step(); k++; end
    repeat (5) step();
    for (int i = 0; i < 2; i++) begin
      e = exp_a_q.pop_front();
      n_tests++;
      if (got_a_q.size() == 0) begin
        n_fail++; $display("FAIL single_stream[%0d]: got nothing expected %0d last %0b", i, e[W-1:0], e[W]);
        cyc[i] = -1;
      end else begin
        g = got_a_q.pop_front(); c = got_a_cyc.pop_front(); cyc[i] = c;
        if (g !== e) begin
          n_fail++; $display("FAIL single_stream[%0d]: got %0d last %0b expected %0d last %0b", i, g[W-1:0], g[W], e[W-1:0], e[W]);
        end
      end
    end
    n_tests++;
    if (cyc[0] != base + 4 || cyc[1] != base + 5) begin
      n_fail++; $display("FAIL single_timing: got edges %0d,%0d expected %0d,%0d", cyc[0] - base, cyc[1] - base, 4, 5);
    end
    n_tests++;
    if (got_a_q.size() != 0) begin n_fail++; $display("FAIL single_extra: got %0d extra words expected 0", got_a_q.size()); end
    n_tests++;
    if (a_popn !== 2'd1 || a_deq_cnt - d0 != 2) begin
      n_fail++; $display("FAIL single_leftover: got population %0d dequeues %0d expected 1 and 2", a_popn, a_deq_cnt - d0);
    end
    n_tests++;
    if (a_state !== IDLE) begin n_fail++; $display("FAIL single_state: got %0d expected IDLE", a_state); end
    do_flush();
  endtask

  task automatic test_backpressure();
    int d0, k;
    logic [W:0] e, g;
    out_ready = 1'b0;
    push_a(8'd100); push_a(8'd255); push_a(8'd120);
    exp_a_q.push_back({1'b0, 8'd100});
    exp_a_q.push_back({1'b1, 8'd255});
    d0 = a_deq_cnt;
    k = 0;
    while (!a_valid && k < 30) begin step(); k++; end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (a_valid !== 1'b1 || a_data !== 8'd100 || a_last !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v%0b data %0d last %0b expected v1 data 100 last 0", i, a_valid, a_data, a_last);
      end
      step();
    end
    out_ready = 1'b1;
    k = 0;
    while (got_a_q.size() < 2 && k < 30) begin step(); k++; end
    repeat (3) step();
    while (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      n_tests++;
      if (got_a_q.size() == 0) begin
        n_fail++; $display("FAIL bp_stream: got nothing expected %0d last %0b", e[W-1:0], e[W]);
      end else begin
        g = got_a_q.pop_front(); void'(got_a_cyc.pop_front());
        if (g !== e) begin
          n_fail++; $display("FAIL bp_stream: got %0d last %0b expected %0d last %0b", g[W-1:0], g[W], e[W-1:0], e[W]);
        end
      end
    end
    n_tests++;
    if (got_a_q.size() != 0 || a_deq_cnt - d0 != 2) begin
      n_fail++; $display("FAIL bp_counts: got %0d extra words, %0d dequeues expected 0 and 2", got_a_q.size(), a_deq_cnt - d0);
    end
    do_flush();
  endtask

  task automatic test_full_rate();
    int base, k, c;
    logic [W:0] e, g;
    out_ready = 1'b1;
    push_b(8'd1); push_b(8'd2); push_b(8'd3);
    exp_b_q.push_back({1'b0, 8'd1});
    exp_b_q.push_back({1'b0, 8'd2});
    exp_b_q.push_back({1'b1, 8'd3});
    base = cycle;
    k = 0;
    while (got_b_q.size() < 3 && k < 30) begin step(); k++; end
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      e = exp_b_q.pop_front();
      n_tests++;
      if (got_b_q.size() == 0) begin
        n_fail++; $display("FAIL full_stream[%0d]: got nothing expected %0d last %0b", i, e[W-1:0], e[W]);
      end else begin
        g = got_b_q.pop_front(); c = got_b_cyc.pop_front();
        if (g !== e || c != base + 4 + i) begin
          n_fail++; $display("FAIL full_stream[%0d]: got %0d last %0b at edge %0d expected %0d last %0b at edge %0d",
                             i, g[W-1:0], g[W], c - base, e[W-1:0], e[W], 4 + i);
        end
      end
    end
    n_tests++;
    if (got_b_q.size() != 0 || b_state !== IDLE || b_popn !== 2'd0) begin
      n_fail++; $display("FAIL full_end: got extra %0d state %0d population %0d expected 0 IDLE 0", got_b_q.size(), b_state, b_popn);
    end
  endtask

  task automatic test_flush_mid_burst();
    int d0, k;
    logic [W:0] e, g;
    out_ready = 1'b1;
    push_a(8'd10); push_a(8'd20); push_a(8'd30);
    d0 = a_deq_cnt;
    k = 0;
    while (a_deq_cnt == d0 && k < 30) begin step(); k++; end
    n_tests++;
    if (a_deq_cnt == d0) begin n_fail++; $display("FAIL flush_wait: got no dequeue expected one within 30 cycles"); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_tests++;
    if (a_valid !== 1'b0 || a_state !== IDLE) begin
      n_fail++; $display("FAIL flush_abort: got valid %0b state %0d expected 0 IDLE", a_valid, a_state);
    end
    repeat (3) step();
    n_tests++;
    if (got_a_q.size() != 0 || a_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_discard: got %0d words valid %0b expected 0 words valid 0", got_a_q.size(), a_valid);
    end
    got_a_q.delete(); got_a_cyc.delete();
    push_a(8'd40); push_a(8'd50);
    exp_a_q.push_back({1'b0, 8'd40});
    exp_a_q.push_back({1'b1, 8'd50});
    k = 0;
    while (got_a_q.size() < 2 && k < 30) begin step(); k++; end
    repeat (3) step();
    while (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      n_tests++;
      if (got_a_q.size() == 0) begin
        n_fail++; $display("FAIL flush_next: got nothing expected %0d last %0b", e[W-1:0], e[W]);
      end else begin
        g = got_a_q.pop_front(); void'(got_a_cyc.pop_front());
        if (g !== e) begin
          n_fail++; $display("FAIL flush_next: got %0d last %0b expected %0d last %0b", g[W-1:0], g[W], e[W-1:0], e[W]);
        end
      end
    end
    n_tests++;
    if (got_a_q.size() != 0) begin n_fail++; $display("FAIL flush_extra: got %0d extra words expected 0", got_a_q.size()); end
  endtask

`ifdef FIFO_READ_ADAPTER_STATS_EN
  task automatic test_stats();
    n_tests++;
    if (a_bcount !== 16'd3) begin n_fail++; $display("FAIL stats_a: got %0d expected 3", a_bcount); end
    n_tests++;
    if (b_bcount !== 16'd1) begin n_fail++; $display("FAIL stats_b: got %0d expected 1", b_bcount); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_single_burst();
    test_backpressure();
    test_full_rate();
    test_flush_mid_burst();
`ifdef FIFO_READ_ADAPTER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_adapter.md
# fifo_read_adapter

Read-side consumer for `mixed_clock_fifo`: runs in the FIFO's `read_clock` domain and drains it in fixed-length bursts. It presents the words as a valid/ready stream with a last-word marker. A 3-entry internal buffer absorbs the FIFO's one-cycle read latency so the stream sustains one word per clock. It sits directly downstream of the FIFO and drives its `dequeue`.

## Interface
- `CAPACITY`, default 3: capacity of the upstream FIFO. Population width is PW = $clog2(CAPACITY+1).
- `BIT_WIDTH`, default 8: data word width.
- `BURST_LEN`, default 2: words per burst. Legal range 1..CAPACITY; out-of-range values are a fatal elaboration error.
- `read_clock`  in  1: single clock. Same clock that drives the FIFO's read side.
- `reset_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous abort. The same net also drives the FIFO's `flush`.
- `fifo_data_out`  in  BIT_WIDTH: FIFO read data. Valid one cycle after an accepted dequeue.
- `fifo_population`  in  PW: FIFO occupancy.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_dequeue`  out  1: read request to the FIFO.
- `out_data`  out  BIT_WIDTH: stream data.
- `out_valid`  out  1: stream valid.
- `out_last`  out  1: marks the final word of a burst.
- `out_ready`  in  1: downstream ready.
- `burst_count`  out  16: present only with `FIFO_READ_ADAPTER_STATS_EN`.

## Operation
- FSM states: IDLE, BURST.
- IDLE → BURST at an edge where `fifo_population >= BURST_LEN` and `flush` = 0. On entry, `issued` = 0.
- `fifo_dequeue` is combinational from registers and `fifo_empty` only; it never depends on `out_ready`.
  - `fifo_dequeue` = (state == BURST) && (`issued` < BURST_LEN) && !`fifo_empty` && (`count` + `inflight`) < 3.
- An accepted dequeue increments `issued` and sets `inflight` = 1 for the next cycle.
- When `inflight` = 1, `fifo_data_out` is written into the buffer at the edge. The entry carries a tag bit: 1 iff it is word BURST_LEN of the burst.
- Stream handshake:
  - `out_valid` = (`count` > 0); `out_data` and `out_last` come from the buffer head.
  - A transfer occurs when `out_valid` && `out_ready`; the head pops at that edge.
  - Once `out_valid` rises, `out_data` and `out_last` hold stable until the transfer.
- BURST → IDLE at the edge where the word with `out_last` = 1 transfers.
- Simultaneous buffer write and pop in the same cycle: `count` is unchanged.
- Buffer pointers wrap modulo 3. Overflow is impossible by construction; an overflow is an assertion failure.
- `flush` = 1 at an edge, in any state:
  - state → IDLE; `count`, `inflight`, `issued` and the pointers are cleared.
  - FIFO data arriving in the following cycle is discarded.
  - Flush has priority over every other event in the same cycle.
- `fifo_empty` rising mid-burst (this happens only after an external flush): dequeue stalls until it falls. No timeout.

## Timing
- Reset values: state IDLE, `fifo_dequeue` 0, `out_valid` 0, `out_last` 0, `out_data` 0, `burst_count` 0.
- Label the edges as follows:
  - Edge E samples the population threshold in IDLE.
  - `fifo_dequeue` is high in the cycle after E.
  - The FIFO pops at E+1.
  - The word is captured at E+2.
  - `out_valid` is high from E+2.
  - First-word latency: 2 cycles after entering BURST.
- Steady state with `out_ready` = 1: one word per cycle.
- A BURST_LEN burst needs BURST_LEN+2 cycles from the BURST entry edge to the last transfer.
- Back-to-back bursts have at least one IDLE cycle between them.
- Reset asserted mid-burst clears everything immediately; in-flight data is lost.

## Configuration
- `FIFO_READ_ADAPTER_STATS_EN` defined:
  - `burst_count` port exists.
  - It increments on each transfer with `out_last` = 1, wrapping from 65535 to 0.
  - It is cleared by reset only; flush does not clear it.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `fifo_read_adapter_pkg` holds:
  - the state enum (IDLE, BURST);
  - the buffer depth constant SKID_DEPTH = 3;
  - the buffer pointer width constant.
- One sub-module: `read_skid_buffer`, a 3-entry circular buffer of {tag, BIT_WIDTH} with write, pop, clear, `count`, head.
- FSM and dequeue logic stay in `fifo_read_adapter`.

## Test plan
- Reset check: pulse `reset_n` low with `out_ready` = 1 and the FIFO empty. All outputs must read 0, and `fifo_dequeue` must stay 0 for 20 cycles.
- Single burst:
  - Enqueue 100, 255, 120 with BURST_LEN = 2 and `out_ready` = 1.
  - Stream must be 100 (last 0) then 255 (last 1) on consecutive cycles.
  - 120 remains in the FIFO (population 1) and no further dequeue occurs.
- Backpressure: same load, with `out_ready` = 0 for 5 cycles after `out_valid` rises.
  - `out_data` holds 100 throughout; `fifo_dequeue` is asserted at most twice.
  - No word is lost or duplicated after release.
- Full rate: BURST_LEN = 3, CAPACITY = 3, FIFO full with 1, 2, 3.
  - Words arrive on 3 consecutive cycles, with `out_last` only on 3.
- Flush mid-burst: assert `flush` on the cycle after the first dequeue.
  - `out_valid` must be 0 after the edge and state must be IDLE.
  - The next burst carries only post-flush data.
- With `FIFO_READ_ADAPTER_STATS_EN`: complete 3 bursts and abort 1 with flush. `burst_count` must be 3.
